// File: rtl/reg_mem_dp.sv
// Dual-read, single-write register memory with a built-in clear sweep after reset or on request.
// Optional REG_MEM_BYPASS_EN: a read that collides with a same-edge write returns the new data.
module reg_mem_dp #(
  parameter int                    DATA_WIDTH  = 8,
  parameter int                    ADDR_BITS   = 5,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_BITS-1:0]  waddr,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  wen,
  input  logic [ADDR_BITS-1:0]  raddr_a,
  input  logic                  ren_a,
  output logic [DATA_WIDTH-1:0] rdata_a,
  output logic                  rvalid_a,
  input  logic [ADDR_BITS-1:0]  raddr_b,
  input  logic                  ren_b,
  output logic [DATA_WIDTH-1:0] rdata_b,
  output logic                  rvalid_b,
  input  logic                  clr_req,
  output logic                  busy
);

  localparam int                   DEPTH    = 1 << ADDR_BITS;
  localparam logic [ADDR_BITS:0]   LAST_PTR = (ADDR_BITS + 1)'(DEPTH - 1);
  localparam logic [ADDR_BITS:0]   PTR_ONE  = (ADDR_BITS + 1)'(1);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_e;

  state_e                  state_q, state_d;
  logic [ADDR_BITS:0]      clr_ptr_q, clr_ptr_d;

  logic                    mem_we;
  logic [ADDR_BITS-1:0]    mem_wa;
  logic [DATA_WIDTH-1:0]   mem_wd;
  logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

  logic                    idle;
  logic                    rd_a_en, rd_b_en;
  logic [DATA_WIDTH-1:0]   rd_a_word, rd_b_word;
  logic [DATA_WIDTH-1:0]   rdata_a_q, rdata_a_d, rdata_b_q, rdata_b_d;
  logic                    rvalid_a_q, rvalid_b_q;

  // Clear engine and write-port arbitration; the sweep owns the write port while active.
  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    mem_we    = 1'b0;
    mem_wa    = waddr;
    mem_wd    = data_in;
    unique case (state_q)
      ST_CLEAR: begin
        mem_we    = 1'b1;
        mem_wa    = clr_ptr_q[ADDR_BITS-1:0];
        mem_wd    = CLEAR_VALUE;
        clr_ptr_d = clr_ptr_q + PTR_ONE;
        if (clr_ptr_q == LAST_PTR) begin
          state_d   = ST_IDLE;
          clr_ptr_d = '0;
        end
      end
      ST_IDLE: begin
        mem_we = wen;
        if (clr_req) begin
          state_d   = ST_CLEAR;
          clr_ptr_d = '0;
        end
      end
      default: begin
        state_d   = ST_CLEAR;
        clr_ptr_d = '0;
      end
    endcase
    if (rst) begin
      mem_we = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_CLEAR;
      clr_ptr_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_wa] <= mem_wd;
    end
  end

  assign idle    = (state_q == ST_IDLE);
  assign rd_a_en = idle && ren_a;
  assign rd_b_en = idle && ren_b;

`ifdef REG_MEM_BYPASS_EN
  assign rd_a_word = (wen && (waddr == raddr_a)) ? data_in : mem_q[raddr_a];
  assign rd_b_word = (wen && (waddr == raddr_b)) ? data_in : mem_q[raddr_b];
`else
  // Collisions return the pre-write contents; the write still lands this edge.
  assign rd_a_word = mem_q[raddr_a];
  assign rd_b_word = mem_q[raddr_b];
`endif

  always_comb begin
    rdata_a_d = rdata_a_q;
    rdata_b_d = rdata_b_q;
    if (rd_a_en) begin
      rdata_a_d = rd_a_word;
    end
    if (rd_b_en) begin
      rdata_b_d = rd_b_word;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_a_q  <= '0;
      rdata_b_q  <= '0;
      rvalid_a_q <= 1'b0;
      rvalid_b_q <= 1'b0;
    end else begin
      rdata_a_q  <= rdata_a_d;
      rdata_b_q  <= rdata_b_d;
      rvalid_a_q <= rd_a_en;
      rvalid_b_q <= rd_b_en;
    end
  end

  assign rdata_a  = rdata_a_q;
  assign rdata_b  = rdata_b_q;
  assign rvalid_a = rvalid_a_q;
  assign rvalid_b = rvalid_b_q;
  assign busy     = (state_q == ST_CLEAR);

endmodule

// File: tb/tb_reg_mem_dp.sv
// Randomised and directed bench for reg_mem_dp against a sweep-counter/array reference model.
module tb_reg_mem_dp;

  localparam int         DW    = 8;
  localparam int         AB    = 5;
  localparam int         DEPTH = 1 << AB;
  localparam logic [7:0] CV    = 8'hFF;

  logic          clk = 1'b0;
  logic          rst;
  logic [AB-1:0] waddr, raddr_a, raddr_b;
  logic [DW-1:0] data_in;
  logic          wen, ren_a, ren_b, clr_req;
  logic [DW-1:0] rdata_a, rdata_b;
  logic          rvalid_a, rvalid_b, busy;

  int checks = 0;
  int errors = 0;

  // Reference model: memory array plus number of sweep writes still outstanding.
  logic [DW-1:0] m_mem [DEPTH];
  int            m_left = DEPTH;
  logic [DW-1:0] exp_a = '0, exp_b = '0;
  logic          exp_va = 1'b0, exp_vb = 1'b0;

  always #5 clk = ~clk;

  reg_mem_dp #(.DATA_WIDTH(DW), .ADDR_BITS(AB), .CLEAR_VALUE(CV)) dut (
    .clk(clk), .rst(rst), .waddr(waddr), .data_in(data_in), .wen(wen),
    .raddr_a(raddr_a), .ren_a(ren_a), .rdata_a(rdata_a), .rvalid_a(rvalid_a),
    .raddr_b(raddr_b), .ren_b(ren_b), .rdata_b(rdata_b), .rvalid_b(rvalid_b),
    .clr_req(clr_req), .busy(busy)
  );

  function automatic logic [DW-1:0] model_read(input logic [AB-1:0] ra);
`ifdef REG_MEM_BYPASS_EN
    if (wen && waddr == ra) return data_in;
`endif
    return m_mem[ra];
  endfunction

  // Advance the model by one edge using the currently driven inputs, then step the DUT.
  task automatic tick();
    if (rst) begin
      m_left = DEPTH;
      exp_a = '0; exp_b = '0; exp_va = 1'b0; exp_vb = 1'b0;
    end else if (m_left > 0) begin
      m_mem[DEPTH - m_left] = CV;
      m_left--;
      exp_va = 1'b0; exp_vb = 1'b0;
    end else begin
      exp_va = ren_a;
      exp_vb = ren_b;
      if (ren_a) exp_a = model_read(raddr_a);
      if (ren_b) exp_b = model_read(raddr_b);
      if (wen) m_mem[waddr] = data_in;
      if (clr_req) m_left = DEPTH;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wen = 0; ren_a = 0; ren_b = 0; clr_req = 0;
    waddr = '0; raddr_a = '0; raddr_b = '0; data_in = '0;
  endtask

  // Counts cycles with busy high, starting from the current sample.
  task automatic count_busy(output int cnt);
    cnt = 0;
    for (int i = 0; i < 100 && busy; i++) begin
      cnt++;
      tick();
    end
  endtask

  task automatic test_reset();
    int cnt;
    idle_inputs();
    rst = 1;
    ren_a = 1; ren_b = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (rdata_a !== 8'h00 || rdata_b !== 8'h00 || rvalid_a !== 1'b0 || rvalid_b !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL reset_state: rdata_a=%h rdata_b=%h rvalid_a=%b rvalid_b=%b busy=%b, want 00 00 0 0 1",
                 rdata_a, rdata_b, rvalid_a, rvalid_b, busy);
      end
    end
    rst = 0; ren_a = 0; ren_b = 0;
    count_busy(cnt);
    checks++;
    if (cnt != DEPTH) begin
      errors++;
      $display("FAIL reset_busy_len: got %0d busy cycles, want %0d", cnt, DEPTH);
    end
  endtask

  task automatic read_all_expect(input logic [DW-1:0] val, input string tag);
    idle_inputs();
    for (int i = 0; i < DEPTH; i++) begin
      ren_a = 1; raddr_a = AB'(i);
      tick();
      checks++;
      if (rdata_a !== val || rvalid_a !== 1'b1) begin
        errors++;
        $display("FAIL %s addr %0d: rdata_a=%h rvalid_a=%b, want %h 1", tag, i, rdata_a, rvalid_a, val);
      end
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_dual_read();
    idle_inputs();
    for (int i = 0; i < 8; i++) begin
      wen = 1; waddr = AB'(12 + i); data_in = DW'(10 + i);
      tick();
    end
    idle_inputs();
    for (int i = 0; i < 8; i++) begin
      ren_a = 1; raddr_a = AB'(12 + i);
      ren_b = 1; raddr_b = AB'(19 - i);
      tick();
      checks++;
      if (rdata_a !== DW'(10 + i) || rdata_b !== DW'(17 - i) || !rvalid_a || !rvalid_b) begin
        errors++;
        $display("FAIL dual_read step %0d: a=%h b=%h va=%b vb=%b, want %h %h 1 1",
                 i, rdata_a, rdata_b, rvalid_a, rvalid_b, DW'(10 + i), DW'(17 - i));
      end
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_collision();
    logic [DW-1:0] want;
`ifdef REG_MEM_BYPASS_EN
    want = 8'h5A;
`else
    want = m_mem[3];
`endif
    idle_inputs();
    wen = 1; waddr = 5'd3; data_in = 8'h5A;
    ren_a = 1; raddr_a = 5'd3;
    tick();
    checks++;
    if (rdata_a !== want || rvalid_a !== 1'b1) begin
      errors++;
      $display("FAIL collision: rdata_a=%h rvalid_a=%b, want %h 1", rdata_a, rvalid_a, want);
    end
    wen = 0;
    tick();
    checks++;
    if (rdata_a !== 8'h5A) begin
      errors++;
      $display("FAIL collision_next: rdata_a=%h, want 5a", rdata_a);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_one_shot();
    logic [DW-1:0] prior_b;
    idle_inputs();
    ren_b = 1; raddr_b = 5'd14;
    tick();
    prior_b = 8'd12;
    ren_b = 0; ren_a = 1; raddr_a = 5'd17;
    tick();
    checks++;
    if (rvalid_a !== 1'b1 || rvalid_b !== 1'b0 || rdata_b !== prior_b || rdata_a !== 8'd15) begin
      errors++;
      $display("FAIL one_shot: va=%b vb=%b a=%h b=%h, want 1 0 0f %h", rvalid_a, rvalid_b, rdata_a, rdata_b, prior_b);
    end
    ren_a = 0;
    tick();
    checks++;
    if (rvalid_a !== 1'b0 || rvalid_b !== 1'b0 || rdata_b !== prior_b) begin
      errors++;
      $display("FAIL one_shot_end: va=%b vb=%b b=%h, want 0 0 %h", rvalid_a, rvalid_b, rdata_b, prior_b);
    end
  endtask

  task automatic test_random();
    idle_inputs();
    for (int n = 0; n < 400; n++) begin
      wen     = ($urandom_range(0, 1) == 1);
      waddr   = AB'($urandom_range(0, DEPTH - 1));
      data_in = DW'($urandom);
      ren_a   = ($urandom_range(0, 2) != 0);
      ren_b   = ($urandom_range(0, 2) != 0);
      raddr_a = ($urandom_range(0, 3) == 0) ? waddr : AB'($urandom_range(0, DEPTH - 1));
      raddr_b = ($urandom_range(0, 3) == 0) ? raddr_a : AB'($urandom_range(0, DEPTH - 1));
      clr_req = ($urandom_range(0, 99) == 0);
      tick();
      checks++;
      if (rdata_a !== exp_a || rdata_b !== exp_b || rvalid_a !== exp_va || rvalid_b !== exp_vb || busy !== (m_left > 0)) begin
        errors++;
        $display("FAIL random cyc %0d: a=%h b=%h va=%b vb=%b busy=%b, want %h %h %b %b %b",
                 n, rdata_a, rdata_b, rvalid_a, rvalid_b, busy, exp_a, exp_b, exp_va, exp_vb, m_left > 0);
      end
    end
    idle_inputs();
    for (int i = 0; i < 100 && busy; i++) tick();
  endtask

  task automatic test_clear_req();
    int cnt;
    int bad_valid;
    idle_inputs();
    for (int i = 0; i < DEPTH; i++) begin
      wen = 1; waddr = AB'(i); data_in = 8'h11;
      tick();
    end
    read_all_expect(8'h11, "fill");
    wen = 1; waddr = 5'd9; data_in = 8'h33; clr_req = 1;
    tick();
    clr_req = 0;
    cnt = 0; bad_valid = 0;
    for (int i = 0; i < 100 && busy; i++) begin
      cnt++;
      wen = 1; waddr = 5'd5; data_in = 8'h22;
      ren_a = 1; ren_b = 1; raddr_a = 5'd5; raddr_b = 5'd5;
      clr_req = (i == 6);
      tick();
      if (rvalid_a || rvalid_b) bad_valid++;
    end
    checks++;
    if (cnt != DEPTH) begin
      errors++;
      $display("FAIL clr_busy_len: got %0d busy cycles, want %0d", cnt, DEPTH);
    end
    checks++;
    if (bad_valid != 0) begin
      errors++;
      $display("FAIL clr_rvalid: got %0d cycles with rvalid during clear, want 0", bad_valid);
    end
    read_all_expect(CV, "after_clr");
  endtask

  task automatic test_rst_mid_sweep();
    int cnt;
    idle_inputs();
    clr_req = 1;
    tick();
    clr_req = 0;
    for (int i = 0; i < 10; i++) tick();
    rst = 1;
    tick();
    rst = 0;
    count_busy(cnt);
    checks++;
    if (cnt != DEPTH) begin
      errors++;
      $display("FAIL rst_mid_sweep_len: got %0d busy cycles, want %0d", cnt, DEPTH);
    end
    read_all_expect(CV, "after_rst_sweep");
  endtask

  task automatic test_rst_mid_read();
    int cnt;
    idle_inputs();
    ren_a = 1; ren_b = 1; raddr_a = 5'd1; raddr_b = 5'd2;
    tick();
    checks++;
    if (rvalid_a !== 1'b1 || rvalid_b !== 1'b1) begin
      errors++;
      $display("FAIL pre_rst_read: va=%b vb=%b, want 1 1", rvalid_a, rvalid_b);
    end
    rst = 1;
    tick();
    rst = 0; ren_a = 0; ren_b = 0;
    checks++;
    if (rvalid_a !== 1'b0 || rvalid_b !== 1'b0 || rdata_a !== 8'h00 || busy !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_read: va=%b vb=%b a=%h busy=%b, want 0 0 00 1", rvalid_a, rvalid_b, rdata_a, busy);
    end
    count_busy(cnt);
    checks++;
    if (cnt != DEPTH) begin
      errors++;
      $display("FAIL rst_read_busy_len: got %0d busy cycles, want %0d", cnt, DEPTH);
    end
  endtask

  initial begin
    idle_inputs();
    rst = 1;
    test_reset();
    read_all_expect(CV, "post_reset");
    test_dual_read();
    test_collision();
    test_one_shot();
    test_random();
    test_clear_req();
    test_rst_mid_sweep();
    test_rst_mid_read();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
